lcd_cmd_seq: RTL and testbench
==============================

# lcd_cmd_seq

Command sequencer sitting directly upstream of the LCD controller. It buffers host-issued 3-bit LCD commands in a small FIFO and issues them one at a time on the controller's `cmd`/`cmd_valid` port, obeying the controller's `busy` handshake and holding `cmd` stable for the whole busy phase. It terminates the session when a Write command completes, signalled by the controller's `done`.

## Interface
- `DEPTH`, default 8: command FIFO entries; power of two, minimum 2.
- `CNT_W`, default 8: width of the issued-command counter.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_cmd`  in  3  host command: 0 write, 1 up, 2 down, 3 left, 4 right, 5 average, 6 mirror X, 7 mirror Y.
- `in_valid`  in  1  host push request.
- `in_ready`  out  1  FIFO can accept; a push happens on a cycle with `in_valid && in_ready`.
- `busy`  in  1  controller busy, registered in the controller.
- `done`  in  1  controller write-complete.
- `cmd`  out  3  command to the controller.
- `cmd_valid`  out  1  one-cycle command strobe.
- `seq_done`  out  1  session finished; sticky until reset.
- `issue_cnt`  out  CNT_W  commands issued since reset; saturates at all-ones.

## Operation
- The FIFO is a circular buffer with read/write pointers and an occupancy count.
  - `in_ready = (count != DEPTH) && !seq_done`. It is combinational.
  - A push and a pop in the same cycle are both performed, and `count` stays unchanged.
  - A push into a full FIFO is impossible because `in_ready` is 0.
- FSM states: IDLE, STROBE, WAIT_HI, WAIT_LO, FINISHED.
- IDLE: if `busy==0` and the FIFO is non-empty:
  - register `cmd <= head` and `cmd_valid <= 1`;
  - pop the FIFO and increment `issue_cnt`;
  - go to STROBE.
  - Otherwise stay in IDLE; this also covers the power-up image load, when `busy` is 1.
- STROBE: `cmd_valid` is high for exactly this cycle. Clear it and go to WAIT_HI.
- WAIT_HI: wait for `busy==1`, then go to WAIT_LO.
- WAIT_LO: wait for `busy==0`.
  - If the last issued cmd was 0 and `done==1`: go to FINISHED.
  - Otherwise go to IDLE.
- FINISHED: `seq_done=1`, `in_ready=0`, and the FIFO is flushed by setting `count` to 0.
  - Host pushes are ignored.
  - Remains in FINISHED until reset.
- `cmd` holds its value from STROBE until the next issue. It never changes while `busy` is high, because the controller decodes `cmd` during its busy phase.
- `done` is ignored outside WAIT_LO.

## Timing
- Reset values:
  - `cmd=0`, `cmd_valid=0`, `seq_done=0`, `issue_cnt=0`;
  - `in_ready=1`;
  - FSM in IDLE, FIFO empty.
- Reset asserted mid-command: immediately returns to these values. No partial strobe survives.
- Issue latency: when the FIFO is non-empty and `busy` is low at edge N, `cmd_valid` is high during cycle N+1 and low again from edge N+2.
- The controller samples the strobe at edge N+2, and `busy` is high from N+2.
- Back-to-back throughput for non-write commands: the next strobe comes at the earliest 2 cycles after `busy` falls.
- A push during cycle k makes the entry poppable at edge k+1.
  - An empty FIFO plus a push while idle gives `cmd_valid` high 2 cycles after the push.

## Structure
- Shared package `lcd_pkg`:
  - command encodings `CMD_WRITE`..`CMD_MIRROR_Y`;
  - FSM state typedef;
  - default `DEPTH`.
- Sub-module `lcd_cmd_fifo`, parameterised by `DEPTH`.
  - Ports: push/pop/flush, data, `full`, `empty`, `count`.
  - The sequencer instantiates one.

## Test plan
- Controller model holds `busy=1` for 66 cycles after reset; push 4 (right) at cycle 3.
  - Required: `cmd_valid` stays 0 until `busy` falls.
  - Then exactly one strobe with `cmd=4`, and `issue_cnt=1`.
- Push 1, 3, 5, 6, 7 back-to-back while the model takes 1 busy cycle per command.
  - Required: five single-cycle strobes in that order.
  - `cmd` is stable while `busy` is high; `issue_cnt=5`.
- Fill all 8 entries while `busy` is held high.
  - Required: `in_ready=0` after the 8th push.
  - A 9th `in_valid` is not accepted.
  - `in_ready` returns to 1 the cycle after the first pop.
- Push 2, then 0, then 4. The model asserts `done` with `busy` falling after the write.
  - Required: strobes for 2 and 0 only.
  - `seq_done=1`, `in_ready=0`, and 4 is never issued.
- Assert `reset` during WAIT_LO with 3 entries queued.
  - Required: all outputs return to their reset values within the same cycle.
  - The FIFO is empty afterwards; no strobe follows until a new push.
- Issue 260 non-write commands.
  - Required: `issue_cnt` saturates at 255.

Source files
------------

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD command sequencer:
//   - 3-bit LCD command encodings understood by the downstream controller
//   - sequencer FSM state type and state constants
//   - default command FIFO depth
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef logic [2:0] lcd_cmd_t;

    localparam lcd_cmd_t CMD_WRITE    = 3'd0;
    localparam lcd_cmd_t CMD_UP       = 3'd1;
    localparam lcd_cmd_t CMD_DOWN     = 3'd2;
    localparam lcd_cmd_t CMD_LEFT     = 3'd3;
    localparam lcd_cmd_t CMD_RIGHT    = 3'd4;
    localparam lcd_cmd_t CMD_AVERAGE  = 3'd5;
    localparam lcd_cmd_t CMD_MIRROR_X = 3'd6;
    localparam lcd_cmd_t CMD_MIRROR_Y = 3'd7;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 3'd0;
    localparam seq_state_t ST_STROBE   = 3'd1;
    localparam seq_state_t ST_WAIT_HI  = 3'd2;
    localparam seq_state_t ST_WAIT_LO  = 3'd3;
    localparam seq_state_t ST_FINISHED = 3'd4;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// -----------------------------------------------------------------------------
// lcd_cmd_fifo
// Circular-buffer FIFO holding pending LCD commands.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write wr_data (ignored when full)
//   pop        : discard the head entry (ignored when empty)
//   flush      : empty the FIFO; takes priority over push/pop
//   wr_data    : command to enqueue
//   rd_data    : current head entry (valid when !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// -----------------------------------------------------------------------------
// lcd_cmd_seq
// Buffers host LCD commands and issues them one at a time to the LCD
// controller, following its busy handshake. The session ends when a Write
// command completes with done asserted.
//   clk, reset : clock, asynchronous active-high reset
//   in_cmd     : host command (see lcd_pkg encodings)
//   in_valid   : host push request
//   in_ready   : FIFO can accept; push on in_valid && in_ready
//   busy       : controller busy (registered in the controller)
//   done       : controller write-complete, only looked at in WAIT_LO
//   cmd        : command to the controller, held until the next issue
//   cmd_valid  : one-cycle issue strobe
//   seq_done   : session finished, sticky until reset
//   issue_cnt  : saturating count of issued commands
// -----------------------------------------------------------------------------
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       in_cmd,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             busy,
    input  logic             done,
    output logic [2:0]       cmd,
    output logic             cmd_valid,
    output logic             seq_done,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    seq_state_t       state;
    lcd_cmd_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             pop;
    logic             flush;

    assign seq_done = (state == ST_FINISHED);
    assign in_ready = (fifo_count != FULL_COUNT) && !seq_done;

    // Same acceptance condition as in_ready, expressed with the FIFO's own
    // full flag.
    assign push  = in_valid && !fifo_full && !seq_done;
    assign pop   = (state == ST_IDLE) && !busy && !fifo_empty;
    assign flush = seq_done;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_cmd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd       <= CMD_WRITE;
            cmd_valid <= 1'b0;
            issue_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Also parks here during the controller's power-up image
                    // load, which it signals by holding busy high.
                    if (pop) begin
                        cmd       <= head;
                        cmd_valid <= 1'b1;
                        if (issue_cnt != '1) begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    cmd_valid <= 1'b0;
                    state     <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    // cmd still holds the command just completed.
                    if (!busy) begin
                        if ((cmd == CMD_WRITE) && done) begin
                            state <= ST_FINISHED;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FINISHED: begin
                    state <= ST_FINISHED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_cmd_seq
// Self-checking bench for lcd_cmd_seq with a behavioural LCD controller model
// and a scoreboard of commands the sequencer is expected to issue.
// -----------------------------------------------------------------------------
module tb_lcd_cmd_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       seq_done;
    logic [7:0] issue_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard and monitor state.
    logic [2:0] sb [$];
    int         n_strobes = 0;
    logic [2:0] last_cmd  = 3'd0;
    logic       prev_valid = 1'b0;

    // Controller model state.
    int  hold       = 1;
    bit  force_busy = 1'b0;
    bit  init_req   = 1'b0;
    int  busy_left  = 0;
    bit  pend       = 1'b0;
    bit  pend_write = 1'b0;
    bit  ibusy      = 1'b0;

    lcd_cmd_seq #(
        .DEPTH (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_cmd    (in_cmd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .seq_done  (seq_done),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // Controller model: busy goes high one cycle after the strobe is seen,
    // stays high for 'hold' cycles, and done pulses as busy falls after a write.
    initial begin
        busy = 1'b0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend       = 1'b0;
                pend_write = 1'b0;
                done       = 1'b0;
                ibusy      = init_req;
                busy_left  = init_req ? 66 : 0;
            end else begin
                done = 1'b0;
                if (pend) begin
                    pend      = 1'b0;
                    ibusy     = 1'b1;
                    busy_left = hold;
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        ibusy = 1'b0;
                        done  = pend_write;
                    end
                end
                if (cmd_valid) begin
                    pend       = 1'b1;
                    pend_write = (cmd == 3'd0);
                end
            end
            busy = force_busy | ibusy;
        end
    end

    // Monitor: checks every strobe against the scoreboard, strobe width, and
    // cmd stability while the controller is busy.
    initial begin
        logic [2:0] exp_c;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                n_strobes  = 0;
                last_cmd   = 3'd0;
                prev_valid = 1'b0;
            end else begin
                if (cmd_valid) begin
                    n_strobes++;
                    checks++;
                    if (prev_valid) begin
                        errors++;
                        $display("FAIL strobe_width: cmd_valid high on consecutive cycles, required single-cycle strobe");
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: cmd=%0d issued, required no strobe", cmd);
                    end else begin
                        exp_c = sb.pop_front();
                        if (cmd !== exp_c) begin
                            errors++;
                            $display("FAIL cmd_order: cmd=%0d, required %0d", cmd, exp_c);
                        end
                    end
                    last_cmd = cmd;
                end else if (busy) begin
                    checks++;
                    if (cmd !== last_cmd) begin
                        errors++;
                        $display("FAIL cmd_stable: cmd=%0d while busy, required %0d", cmd, last_cmd);
                    end
                end
                prev_valid = cmd_valid;
            end
        end
    end

    task automatic apply_reset(input bit init);
        in_valid   = 1'b0;
        in_cmd     = 3'd0;
        force_busy = 1'b0;
        init_req   = init;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        sb.delete();
        @(posedge clk);
        #2;
        reset    = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] c, input bit expect_issue);
        int g;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready=0 for 200 cycles, required 1");
        end else begin
            in_cmd   = c;
            in_valid = 1'b1;
            if (expect_issue) sb.push_back(c);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int g;
        g = 0;
        while (sb.size() != 0 && g < max_cycles) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d commands still pending, required 0", sb.size());
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic check_issue_cnt(input string name, input logic [7:0] exp_cnt, input int exp_strobes);
        checks++;
        if (issue_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_issue_cnt: issue_cnt=%0d, required %0d", name, issue_cnt, exp_cnt);
        end
        checks++;
        if (n_strobes != exp_strobes) begin
            errors++;
            $display("FAIL %s_strobes: %0d strobes, required %0d", name, n_strobes, exp_strobes);
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        @(negedge clk);
        checks++;
        if (cmd !== 3'd0 || cmd_valid !== 1'b0 || seq_done !== 1'b0 ||
            issue_cnt !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: cmd=%0d cmd_valid=%b seq_done=%b issue_cnt=%0d in_ready=%b, required 0 0 0 0 1",
                     cmd, cmd_valid, seq_done, issue_cnt, in_ready);
        end
    endtask

    task automatic test_power_up();
        bit early;
        int g;
        early = 1'b0;
        g = 0;
        @(negedge clk);
        push_cmd(3'd4, 1'b1);
        while (busy && g < 200) begin
            if (cmd_valid) early = 1'b1;
            @(negedge clk);
            g++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL powerup_busy: busy still 1 after 200 cycles, required 0");
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL powerup_hold: cmd_valid=1 during power-up busy, required 0");
        end
        wait_drain(50);
        check_issue_cnt("powerup", 8'd1, 1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [5];
        seq = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd7};
        apply_reset(1'b0);
        hold = 1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) push_cmd(seq[i], 1'b1);
        wait_drain(200);
        check_issue_cnt("b2b", 8'd5, 5);
    endtask

    task automatic test_fill();
        bit ready_early;
        int g;
        ready_early = 1'b0;
        g = 0;
        apply_reset(1'b0);
        hold       = 1;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) push_cmd(3'((i % 7) + 1), 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: in_ready=%b after 8 pushes, required 0", in_ready);
        end
        // Ninth request must not be taken.
        in_cmd   = 3'd5;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ninth: in_ready=%b on 9th request, required 0", in_ready);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        force_busy = 1'b0;
        while (!cmd_valid && g < 20) begin
            if (in_ready) ready_early = 1'b1;
            @(negedge clk);
            g++;
        end
        checks++;
        if (!cmd_valid || ready_early) begin
            errors++;
            $display("FAIL fill_first_pop: cmd_valid=%b ready_before_pop=%b, required 1 0", cmd_valid, ready_early);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready_back: in_ready=%b after first pop, required 1", in_ready);
        end
        wait_drain(300);
        check_issue_cnt("fill", 8'd8, 8);
    endtask

    task automatic test_write();
        int g;
        g = 0;
        apply_reset(1'b0);
        hold = 2;
        @(negedge clk);
        push_cmd(3'd2, 1'b1);
        push_cmd(3'd0, 1'b1);
        push_cmd(3'd4, 1'b0);
        while (!seq_done && g < 300) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (seq_done !== 1'b1) begin
            errors++;
            $display("FAIL write_seq_done: seq_done=%b, required 1", seq_done);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_in_ready: in_ready=%b after finish, required 0", in_ready);
        end
        // Pushes after the session ends are ignored.
        in_cmd   = 3'd3;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (seq_done !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL write_sticky: seq_done=%b pending=%0d, required 1 0", seq_done, sb.size());
        end
        check_issue_cnt("write", 8'd2, 2);
    endtask

    task automatic test_reset_mid();
        int g;
        g = 0;
        apply_reset(1'b0);
        hold = 20;
        @(negedge clk);
        push_cmd(3'd1, 1'b1);
        push_cmd(3'd3, 1'b0);
        push_cmd(3'd5, 1'b0);
        push_cmd(3'd6, 1'b0);
        while (!busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || issue_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midreset_setup: busy=%b issue_cnt=%0d, required 1 1", busy, issue_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (cmd !== 3'd0 || cmd_valid !== 1'b0 || seq_done !== 1'b0 ||
            issue_cnt !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_values: cmd=%0d cmd_valid=%b seq_done=%b issue_cnt=%0d in_ready=%b, required 0 0 0 0 1",
                     cmd, cmd_valid, seq_done, issue_cnt, in_ready);
        end
        repeat (3) @(negedge clk);
        sb.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_issue_cnt("midreset_empty", 8'd0, 0);
        // Empty FIFO, idle controller: strobe two cycles after the push.
        hold = 1;
        push_cmd(3'd7, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: cmd_valid=%b one cycle after push, required 0", cmd_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd7) begin
            errors++;
            $display("FAIL latency: cmd_valid=%b cmd=%0d two cycles after push, required 1 7", cmd_valid, cmd);
        end
        wait_drain(50);
        check_issue_cnt("latency", 8'd1, 1);
    endtask

    task automatic test_saturate();
        apply_reset(1'b0);
        hold = 1;
        @(negedge clk);
        for (int i = 0; i < 260; i++) push_cmd(3'($urandom_range(1, 7)), 1'b1);
        wait_drain(2000);
        check_issue_cnt("saturate", 8'hFF, 260);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = 3'd0;
        test_reset();
        test_power_up();
        test_back_to_back();
        test_fill();
        test_write();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
